// File: rtl/framebuffer_loader.sv
// UART command decoder that loads frames, single rows or a clear pattern into
// the framebuffer's byte-wide write port, and owns the per-channel RGB enable.
module framebuffer_loader #(
  parameter int ADDR_WIDTH     = 12,
  parameter int ROW_BYTES      = 128,
  parameter int TIMEOUT_WIDTH  = 20,
  parameter int TIMEOUT_CYCLES = 532000
) (
  input  logic                  clk_in,
  input  logic                  reset,
  input  logic [7:0]            rx_data,
  input  logic                  rx_valid,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [7:0]            ram_data,
  output logic                  ram_wr,
  output logic [2:0]            rgb_enable,
  output logic                  busy,
  output logic                  load_done,
  output logic                  load_error
);

  localparam int FRAME_BYTES = 1 << ADDR_WIDTH;
  localparam int REM_WIDTH   = ADDR_WIDTH + 1;
  localparam logic [TIMEOUT_WIDTH-1:0] TIMEOUT_LAST = TIMEOUT_WIDTH'(TIMEOUT_CYCLES - 1);

  localparam logic [7:0] CMD_FRAME  = 8'h46;
  localparam logic [7:0] CMD_ROW    = 8'h52;
  localparam logic [7:0] CMD_CLEAR  = 8'h43;
  localparam logic [7:0] CMD_ENABLE = 8'h45;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ROW_SEL,
    ST_ENABLE_ARG,
    ST_DATA,
    ST_CLEAR
  } state_t;

  state_t                  r_state, w_state;
  logic [ADDR_WIDTH-1:0]   r_ptr, w_ptr;
  logic [REM_WIDTH-1:0]    r_remaining, w_remaining;
  logic [TIMEOUT_WIDTH-1:0] r_timeout, w_timeout;
  logic [ADDR_WIDTH-1:0]   r_ram_addr, w_ram_addr;
  logic [7:0]              r_ram_data, w_ram_data;
  logic                    r_ram_wr, w_ram_wr;
  logic [2:0]              r_rgb_enable, w_rgb_enable;
  logic                    r_busy;
  logic                    r_load_done, w_load_done;
  logic                    r_load_error, w_load_error;
  logic                    w_timed;

  always_comb begin
    // NOTE: every w_ signal is defaulted first so no path through the case leaves a latch.
    w_state      = r_state;
    w_ptr        = r_ptr;
    w_remaining  = r_remaining;
    w_timeout    = '0;
    w_ram_addr   = r_ram_addr;
    w_ram_data   = r_ram_data;
    w_ram_wr     = 1'b0;
    w_rgb_enable = r_rgb_enable;
    w_load_done  = 1'b0;
    w_load_error = 1'b0;
    w_timed      = 1'b0;

    unique case (r_state)
      ST_IDLE: begin
        if (rx_valid) begin
          unique case (rx_data)
            CMD_FRAME: begin
              w_ptr       = '0;
              w_remaining = REM_WIDTH'(FRAME_BYTES);
              w_state     = ST_DATA;
            end
            CMD_ROW:    w_state = ST_ROW_SEL;
            CMD_CLEAR: begin
              w_ptr      = '0;
              w_ram_addr = '0;
              w_state    = ST_CLEAR;
            end
            CMD_ENABLE: w_state = ST_ENABLE_ARG;
            default:    w_state = ST_IDLE;
          endcase
        end
      end

      ST_ROW_SEL: begin
        w_timed = 1'b1;
        if (rx_valid) begin
          w_ptr       = ADDR_WIDTH'(32'(rx_data[4:0]) * ROW_BYTES);
          w_remaining = REM_WIDTH'(ROW_BYTES);
          w_state     = ST_DATA;
        end
      end

      ST_ENABLE_ARG: begin
        w_timed = 1'b1;
        if (rx_valid) begin
          w_rgb_enable = rx_data[2:0];
          w_state      = ST_IDLE;
        end
      end

      ST_DATA: begin
        w_timed = 1'b1;
        if (rx_valid) begin
          w_ram_wr    = 1'b1;
          w_ram_data  = rx_data;
          w_ram_addr  = r_ptr;
          w_ptr       = r_ptr + ADDR_WIDTH'(1);
          w_remaining = r_remaining - REM_WIDTH'(1);
          if (r_remaining == REM_WIDTH'(1)) begin
            w_load_done = 1'b1;
            w_state     = ST_IDLE;
          end
        end
      end

      ST_CLEAR: begin
        // Incoming bytes are ignored here; the sweep runs unconditionally.
        w_ram_wr   = 1'b1;
        w_ram_data = '0;
        w_ram_addr = r_ptr;
        w_ptr      = r_ptr + ADDR_WIDTH'(1);
        if (r_ptr == '1) begin
          w_load_done = 1'b1;
          w_state     = ST_IDLE;
        end
      end

      default: w_state = ST_IDLE;
    endcase

    // A byte arriving on the expiry cycle wins over the timeout.
    if (w_timed && !rx_valid) begin
      if (r_timeout == TIMEOUT_LAST) begin
        w_load_error = 1'b1;
        w_state      = ST_IDLE;
      end else begin
        w_timeout = r_timeout + TIMEOUT_WIDTH'(1);
      end
    end
  end

  // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
  always_ff @(posedge clk_in) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_ptr        <= '0;
      r_remaining  <= '0;
      r_timeout    <= '0;
      r_ram_addr   <= '0;
      r_ram_data   <= '0;
      r_ram_wr     <= 1'b0;
      r_rgb_enable <= 3'b111;
      r_busy       <= 1'b0;
      r_load_done  <= 1'b0;
      r_load_error <= 1'b0;
    end else begin
      r_state      <= w_state;
      r_ptr        <= w_ptr;
      r_remaining  <= w_remaining;
      r_timeout    <= w_timeout;
      r_ram_addr   <= w_ram_addr;
      r_ram_data   <= w_ram_data;
      r_ram_wr     <= w_ram_wr;
      r_rgb_enable <= w_rgb_enable;
      r_busy       <= (w_state != ST_IDLE);
      r_load_done  <= w_load_done;
      r_load_error <= w_load_error;
    end
  end

  assign ram_addr   = r_ram_addr;
  assign ram_data   = r_ram_data;
  assign ram_wr     = r_ram_wr;
  assign rgb_enable = r_rgb_enable;
  assign busy       = r_busy;
  assign load_done  = r_load_done;
  assign load_error = r_load_error;

endmodule

// File: tb/tb_framebuffer_loader.sv
// Directed/randomized bench for framebuffer_loader: expected writes come from a
// protocol-level model (address ranges and byte lists) held in queues.
module tb_framebuffer_loader;

  localparam int AW = 12;
  localparam int RB = 128;
  localparam int T  = 64;

  logic          clk_in = 1'b0;
  logic          reset;
  logic [7:0]    rx_data;
  logic          rx_valid;
  logic [AW-1:0] ram_addr;
  logic [7:0]    ram_data;
  logic          ram_wr;
  logic [2:0]    rgb_enable;
  logic          busy;
  logic          load_done;
  logic          load_error;

  framebuffer_loader #(
    .ADDR_WIDTH    (AW),
    .ROW_BYTES     (RB),
    .TIMEOUT_WIDTH (20),
    .TIMEOUT_CYCLES(T)
  ) dut (
    .clk_in    (clk_in),
    .reset     (reset),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .ram_addr  (ram_addr),
    .ram_data  (ram_data),
    .ram_wr    (ram_wr),
    .rgb_enable(rgb_enable),
    .busy      (busy),
    .load_done (load_done),
    .load_error(load_error)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    int addr;
    int data;
    bit done;
    int cyc;
  } wr_t;

  wr_t act_q[$];
  wr_t exp_q[$];
  int  rx_cyc_q[$];
  int  cyc = 0;
  int  done_cnt = 0;
  int  err_cnt = 0;
  int  err_cyc = 0;
  int  n_checks = 0;
  int  n_pass = 0;
  int  act_base = 0;

  always @(posedge clk_in) cyc <= cyc + 1;

  // Passive monitor: every write and pulse is logged with the cycle it was seen in.
  always @(negedge clk_in) begin
    if (ram_wr) act_q.push_back('{int'(ram_addr), int'(ram_data), load_done, cyc});
    if (load_done) done_cnt <= done_cnt + 1;
    if (load_error) begin
      err_cnt <= err_cnt + 1;
      err_cyc <= cyc;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, observed cycle %0d required < 200000", cyc);
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input int expv);
    n_checks++;
    assert (obs === 32'(expv)) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
  endtask

  // Called on a falling edge; the byte is sampled by the next rising edge.
  task automatic send(input logic [7:0] b, input int gap, input bit track);
    rx_data  = b;
    rx_valid = 1'b1;
    if (track) rx_cyc_q.push_back(cyc);
    @(negedge clk_in);
    rx_valid = 1'b0;
    repeat (gap) @(negedge clk_in);
  endtask

  task automatic settle(input int n);
    repeat (n) @(negedge clk_in);
  endtask

  task automatic compare_writes(input string tag, input bit chk_lat);
    int  n;
    int  nmis;
    int  nlat;
    wr_t a;
    n    = act_q.size() - act_base;
    nmis = 0;
    nlat = 0;
    check({tag, "_count"}, n, exp_q.size());
    for (int i = 0; i < n && i < exp_q.size(); i++) begin
      a = act_q[act_base + i];
      if (a.addr != exp_q[i].addr || a.data != exp_q[i].data || a.done != exp_q[i].done)
        nmis++;
      if (chk_lat && i < rx_cyc_q.size() && (a.cyc - rx_cyc_q[i]) != 1) nlat++;
    end
    check({tag, "_content"}, nmis, 0);
    if (chk_lat) check({tag, "_latency"}, nlat, 0);
    exp_q.delete();
    rx_cyc_q.delete();
    act_base = act_q.size();
  endtask

  initial begin
    int       done_base;
    int       err_base;
    int       wait_n;
    int       c_cyc;
    int       ncons;
    int       first_lat;
    int       last_rx;
    int       gap;
    logic [7:0] d;
    logic [7:0] row_byte;
    logic [7:0] inj [6];

    reset    = 1'b1;
    rx_valid = 1'b0;
    rx_data  = '0;
    settle(3);
    check("rst_addr", ram_addr, 0);
    check("rst_data", ram_data, 0);
    check("rst_wr", ram_wr, 0);
    check("rst_rgb", rgb_enable, 7);
    check("rst_busy", busy, 0);
    check("rst_done", load_done, 0);
    check("rst_error", load_error, 0);
    reset = 1'b0;
    settle(2);

    // Enable register update: no writes, busy only while the argument is pending.
    send(8'h45, 0, 0);
    check("en_busy_pending", busy, 1);
    send(8'h05, 2, 0);
    check("en_rgb", rgb_enable, 5);
    check("en_busy_idle", busy, 0);
    check("en_no_wr", act_q.size(), 0);

    // Row load: upper bits of the row byte are ignored.
    done_base = done_cnt;
    row_byte  = 8'h23;
    send(8'h52, 0, 0);
    send(row_byte, $urandom_range(0, 2), 0);
    for (int i = 0; i < RB; i++) begin
      exp_q.push_back('{(row_byte % 32) * RB + i, i, (i == RB - 1), 0});
      send(8'(i), $urandom_range(0, 2), 1);
    end
    settle(3);
    compare_writes("row", 1);
    check("row_done_cnt", done_cnt - done_base, 1);
    check("row_busy", busy, 0);

    // Whole frame with three idle cycles between bytes.
    done_base = done_cnt;
    send(8'h46, 0, 0);
    for (int i = 0; i < (1 << AW); i++) begin
      d = 8'($urandom_range(0, 255));
      exp_q.push_back('{i, int'(d), (i == (1 << AW) - 1), 0});
      send(d, 3, 1);
    end
    settle(8);
    compare_writes("frame", 1);
    check("frame_done_cnt", done_cnt - done_base, 1);
    check("frame_busy", busy, 0);

    // Clear with bytes (including commands) injected while it runs.
    done_base = done_cnt;
    inj[0] = 8'h45; inj[1] = 8'h00; inj[2] = 8'h46;
    inj[3] = 8'h52; inj[4] = 8'h43; inj[5] = 8'($urandom_range(0, 255));
    c_cyc = cyc;
    send(8'h43, 0, 0);
    for (int k = 0; k < 4000; k++) begin
      if ($urandom_range(0, 7) == 0) send(inj[$urandom_range(0, 5)], 0, 0);
      else @(negedge clk_in);
    end
    wait_n = 0;
    while (done_cnt == done_base && wait_n < 400) begin
      @(negedge clk_in);
      wait_n++;
    end
    settle(4);
    ncons     = 0;
    first_lat = -1;
    if (act_q.size() > act_base) begin
      first_lat = act_q[act_base].cyc - c_cyc;
      for (int i = 1; i < act_q.size() - act_base; i++)
        if (act_q[act_base + i].cyc != act_q[act_base].cyc + i) ncons++;
    end
    check("clr_start_1_or_2", (first_lat == 1 || first_lat == 2), 1);
    check("clr_consecutive", ncons, 0);
    for (int i = 0; i < (1 << AW); i++) exp_q.push_back('{i, 0, (i == (1 << AW) - 1), 0});
    compare_writes("clr", 0);
    check("clr_done_cnt", done_cnt - done_base, 1);
    check("clr_rgb_kept", rgb_enable, 5);
    check("clr_busy", busy, 0);

    // Timeout: two gaps of T-1 idle cycles must survive, a final stall of T must not.
    done_base = done_cnt;
    err_base  = err_cnt;
    send(8'h46, 0, 0);
    for (int i = 0; i < 10; i++) begin
      d   = 8'($urandom_range(0, 255));
      gap = (i == 3 || i == 6) ? T - 1 : $urandom_range(0, 3);
      if (i == 9) gap = 0;
      exp_q.push_back('{i, int'(d), 1'b0, 0});
      send(d, gap, 1);
    end
    last_rx = rx_cyc_q[rx_cyc_q.size() - 1];
    wait_n  = 0;
    while (err_cnt == err_base && wait_n < T + 40) begin
      @(negedge clk_in);
      wait_n++;
    end
    settle(3);
    check("to_error_cnt", err_cnt - err_base, 1);
    check("to_idle_cycles", err_cyc - last_rx - 1, T);
    check("to_no_done", done_cnt - done_base, 0);
    check("to_busy", busy, 0);
    compare_writes("to", 1);
    send(8'h45, 0, 0);
    send(8'h02, 2, 0);
    check("to_then_rgb", rgb_enable, 2);

    // Reset in the middle of row data.
    done_base = done_cnt;
    err_base  = err_cnt;
    row_byte  = 8'($urandom_range(0, 255));
    send(8'h52, 0, 0);
    send(row_byte, 0, 0);
    for (int i = 0; i < 40; i++) begin
      d = 8'($urandom_range(0, 255));
      exp_q.push_back('{(row_byte % 32) * RB + i, int'(d), 1'b0, 0});
      send(d, $urandom_range(0, 1), 1);
    end
    reset = 1'b1;
    @(negedge clk_in);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_rgb", rgb_enable, 7);
    check("mid_rst_wr", ram_wr, 0);
    reset = 1'b0;
    for (int i = 0; i < 20; i++) send(8'h10 + 8'(i), 0, 0);
    settle(T + 10);
    compare_writes("mid_rst", 0);
    check("mid_rst_no_done", done_cnt - done_base, 0);
    check("mid_rst_no_error", err_cnt - err_base, 0);
    check("mid_rst_busy_after", busy, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/framebuffer_loader.md
Name: framebuffer_loader

Overview:
Upstream write-side stage for the framebuffer. It consumes bytes from the UART receiver and decodes a small command protocol. It drives the framebuffer's byte-wide port A (12-bit byte address, 8-bit data) to load whole frames, single rows, or a clear. It also holds the rgb_enable register that gates the pixel split stages.

Parameters:
ADDR_WIDTH, 12, framebuffer port A byte address width (4096 bytes = 2048 RGB565 pixels)
ROW_BYTES, 128, bytes per matrix row (64 px x 2 bytes)
TIMEOUT_WIDTH, 20, width of the inter-byte timeout counter
TIMEOUT_CYCLES, 532000, idle clk_in cycles tolerated between bytes inside a command (10 ms at 53.2 MHz)

Ports:
clk_in  input  1  system clock (clk_root domain)
reset  input  1  synchronous, active-high reset
rx_data  input  8  received UART byte, valid only when rx_valid=1
rx_valid  input  1  one-cycle strobe per received byte
ram_addr  output  ADDR_WIDTH  framebuffer port A byte address
ram_data  output  8  framebuffer port A write data
ram_wr  output  1  port A write enable / clock enable, one cycle per byte
rgb_enable  output  3  per-channel enable {B,G,R}
busy  output  1  high in any state other than IDLE
load_done  output  1  one-cycle pulse when a frame, row or clear completes
load_error  output  1  one-cycle pulse when a command is aborted by timeout

Behaviour:
- Reset values: ram_addr=0, ram_data=0, ram_wr=0, rgb_enable=3'b111, busy=0, load_done=0, load_error=0, state=IDLE, byte counter=0, timeout counter=0.
- Reset is checked before all else. Reset mid-command aborts at once, with no load_done or load_error pulse. rgb_enable returns to 3'b111.
- States: IDLE, ROW_SEL, ENABLE_ARG, DATA, CLEAR.
- In IDLE, on rx_valid:
  - 0x46 'F': ram_addr base=0, remaining=4096, go to DATA.
  - 0x52 'R': go to ROW_SEL.
  - 0x43 'C': ram_addr=0, go to CLEAR.
  - 0x45 'E': go to ENABLE_ARG.
  - Any other byte is ignored and the state stays IDLE.
- ROW_SEL, on rx_valid: row = rx_data[4:0] (bits 7:5 ignored). Base = row*ROW_BYTES, remaining=ROW_BYTES, go to DATA.
- ENABLE_ARG, on rx_valid: rgb_enable <= rx_data[2:0], then go to IDLE. No load_done pulse.
- DATA, on each rx_valid:
  - The next cycle has ram_wr=1, ram_data=rx_data and ram_addr=current address. Latency is exactly 1 cycle from rx_valid to ram_wr.
  - The address then increments by 1 and remaining decrements.
  - Byte order within a pixel: high byte (R5G3) at the even address, then the low byte.
  - When the final byte is written, load_done pulses in the same cycle as that ram_wr, and the state goes to IDLE.
  - A frame write ends at address 4095. The address counter must not wrap into a second pass.
- CLEAR:
  - ram_wr=1 and ram_data=0 every cycle for addresses 0..4095, i.e. 4096 consecutive cycles.
  - load_done pulses with the write to address 4095, then the state goes to IDLE.
  - rx_valid during CLEAR is dropped silently.
- ram_wr is 0 in every cycle not listed above. ram_addr and ram_data hold their last values when ram_wr=0.
- Timeout: applies only in ROW_SEL, ENABLE_ARG and DATA.
  - The counter clears on state entry and on every rx_valid, and increments otherwise.
  - On reaching TIMEOUT_CYCLES: load_error pulses for one cycle, the state goes to IDLE, and bytes already written stay written.
  - If rx_valid arrives in the same cycle the count reaches TIMEOUT_CYCLES, the byte wins and there is no error.
- rx_valid in the cycle that load_done or load_error is issued is interpreted in IDLE on the next cycle only if it arrives then. Bytes arriving during the transition cycle are treated as IDLE command bytes.
- busy = (state != IDLE), registered with the state.

Test Plan:
- Reset, then send 'E' followed by 0x05 -> rgb_enable=3'b101, no ram_wr, busy returns to 0.
- Send 'R', 0x23, then 128 bytes 0x00..0x7F -> writes to addresses 384..511 with data 0x00..0x7F (row 3; bit 5 ignored). load_done coincides with the write of 0x7F at 511.
- Send 'F' plus 4096 bytes with 3 idle cycles between bytes -> 4096 writes at addresses 0..4095, each 1 cycle after rx_valid. One load_done pulse, no address wrap.
- Send 'C', injecting rx_valid bytes during the clear -> exactly 4096 consecutive writes of 0x00. Injected bytes are dropped. load_done fires at address 4095.
- Send 'F' plus 10 bytes, then stall TIMEOUT_CYCLES -> 10 writes, a load_error pulse, IDLE. A following 'E' 0x02 yields rgb_enable=3'b010.
- Assert reset for one cycle midway through 'R' data -> state IDLE, no further ram_wr, rgb_enable=3'b111, no load_done or load_error pulse.
